// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Opcode in / decoded control-flag out bundle for control_unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
    logic [5:0] opcode;
    logic       ALU;
    logic       BRA;
    logic       L;
    logic       S;
    logic       TR;
    logic       IMM;
    logic       STACK;
    logic       MOV;

    modport master (
        output opcode,
        input  ALU, BRA, L, S, TR, IMM, STACK, MOV
    );

    modport slave (
        input  opcode,
        output ALU, BRA, L, S, TR, IMM, STACK, MOV
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Registered 6-bit opcode decoder producing instruction-class
//                flags. Optional stack opcodes 0x3C-0x3F: CU_STACK_OPS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit (
    input  wire logic         clk,
    input  wire logic         rst,
    control_unit_if.slave     bus
);

    typedef struct packed {
        logic alu;
        logic bra;
        logic l;
        logic s;
        logic tr;
        logic imm;
        logic stack;
        logic mov;
    } flags_t;

    flags_t w_dec;

    // Opcode space splits into quarters on [5:4], then 4-opcode groups on [3:2].
    always_comb begin
        w_dec = '0;
        case (bus.opcode[5:4])
            2'b00: w_dec.alu = (bus.opcode[3:0] != 4'h0);
            2'b01: begin
                w_dec.alu = 1'b1;
                w_dec.imm = 1'b1;
            end
            2'b10: begin
                case (bus.opcode[3:2])
                    2'b00:   w_dec.l = 1'b1;
                    2'b01:   w_dec.s = 1'b1;
                    2'b10: begin
                        w_dec.l   = 1'b1;
                        w_dec.imm = 1'b1;
                    end
                    default: w_dec.mov = 1'b1;
                endcase
            end
            default: begin
                case (bus.opcode[3:2])
                    2'b00:   w_dec.bra = 1'b1;
                    2'b01: begin
                        w_dec.bra = 1'b1;
                        w_dec.imm = 1'b1;
                    end
                    2'b10:   w_dec.tr = 1'b1;
                    default: begin
`ifdef CU_STACK_OPS_EN
                        w_dec.stack = 1'b1;
                        case (bus.opcode[1:0])
                            2'b00:   w_dec.s   = 1'b1;
                            2'b01:   w_dec.l   = 1'b1;
                            default: w_dec.bra = 1'b1;
                        endcase
`else
                        // Stack opcodes decode as NOP when the feature is absent.
                        w_dec = '0;
`endif
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ALU   <= 1'b0;
            bus.BRA   <= 1'b0;
            bus.L     <= 1'b0;
            bus.S     <= 1'b0;
            bus.TR    <= 1'b0;
            bus.IMM   <= 1'b0;
            bus.STACK <= 1'b0;
            bus.MOV   <= 1'b0;
        end else begin
            bus.ALU   <= w_dec.alu;
            bus.BRA   <= w_dec.bra;
            bus.L     <= w_dec.l;
            bus.S     <= w_dec.s;
            bus.TR    <= w_dec.tr;
            bus.IMM   <= w_dec.imm;
            bus.STACK <= w_dec.stack;
            bus.MOV   <= w_dec.mov;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit (vector table, opcode
//                sweep, random opcodes vs. range-based model, reset cases).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    control_unit_if bus ();

    control_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector order: {ALU, BRA, L, S, TR, IMM, STACK, MOV}
    typedef struct {
        logic [5:0] op;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [7:0] outs();
        return {bus.ALU, bus.BRA, bus.L, bus.S, bus.TR, bus.IMM, bus.STACK, bus.MOV};
    endfunction

    // Reference decode written from the opcode range table.
    function automatic logic [7:0] model(input int op);
        bit alu = 0, bra = 0, ld = 0, st = 0, tr = 0, imm = 0, stk = 0, mov = 0;
        if (op >= 8'h01 && op <= 8'h0F) alu = 1;
        else if (op >= 8'h10 && op <= 8'h1F) begin alu = 1; imm = 1; end
        else if (op >= 8'h20 && op <= 8'h23) ld = 1;
        else if (op >= 8'h24 && op <= 8'h27) st = 1;
        else if (op >= 8'h28 && op <= 8'h2B) begin ld = 1; imm = 1; end
        else if (op >= 8'h2C && op <= 8'h2F) mov = 1;
        else if (op >= 8'h30 && op <= 8'h37) begin bra = 1; imm = (op >= 8'h34); end
        else if (op >= 8'h38 && op <= 8'h3B) tr = 1;
`ifdef CU_STACK_OPS_EN
        else if (op == 8'h3C) begin stk = 1; st = 1; end
        else if (op == 8'h3D) begin stk = 1; ld = 1; end
        else if (op >= 8'h3E && op <= 8'h3F) begin stk = 1; bra = 1; end
`endif
        return {alu, bra, ld, st, tr, imm, stk, mov};
    endfunction

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // Drive opcode away from the active edge, sample 1 time unit after it.
    task automatic step(input logic [5:0] op);
        @(negedge clk);
        bus.opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] o;
        int         cls;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{6'h00, 8'b0000_0000, "nop"};
        vecs[1]  = '{6'h05, 8'b1000_0000, "alu_05"};
        vecs[2]  = '{6'h0F, 8'b1000_0000, "alu_0f"};
        vecs[3]  = '{6'h15, 8'b1000_0100, "alu_imm_15"};
        vecs[4]  = '{6'h20, 8'b0010_0000, "load_20"};
        vecs[5]  = '{6'h27, 8'b0001_0000, "store_27"};
        vecs[6]  = '{6'h28, 8'b0010_0100, "load_imm_28"};
        vecs[7]  = '{6'h2C, 8'b0000_0001, "mov_2c"};
        vecs[8]  = '{6'h33, 8'b0100_0000, "bra_33"};
        vecs[9]  = '{6'h34, 8'b0100_0100, "bra_imm_34"};
        vecs[10] = '{6'h3B, 8'b0000_1000, "tr_3b"};
`ifdef CU_STACK_OPS_EN
        vecs[11] = '{6'h3C, 8'b0001_0010, "push_3c"};
        vecs[12] = '{6'h3D, 8'b0010_0010, "pop_3d"};
        vecs[13] = '{6'h3E, 8'b0100_0010, "call_3e"};
        vecs[14] = '{6'h3F, 8'b0100_0010, "ret_3f"};
`else
        vecs[11] = '{6'h3C, 8'b0000_0000, "push_3c_off"};
        vecs[12] = '{6'h3D, 8'b0000_0000, "pop_3d_off"};
        vecs[13] = '{6'h3E, 8'b0000_0000, "call_3e_off"};
        vecs[14] = '{6'h3F, 8'b0000_0000, "ret_3f_off"};
`endif
        vecs[15] = '{6'h1F, 8'b1000_0100, "alu_imm_1f"};

        // Asynchronous clear before any clock edge, with a stack opcode present.
        rst        = 1'b0;
        bus.opcode = 6'h3F;
        #1 rst = 1'b1;
        #1 check("reset_async", outs(), 8'h00);
        repeat (2) @(posedge clk);
        #1 check("reset_held", outs(), 8'h00);

        // First edge after release reflects the opcode at that edge.
        @(negedge clk);
        bus.opcode = 6'h05;
        rst        = 1'b0;
        @(posedge clk);
        #1 check("post_reset_05", outs(), 8'b1000_0000);
        step(6'h15);
        check("post_reset_15", outs(), 8'b1000_0100);

        foreach (vecs[i]) begin
            step(vecs[i].op);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Full sweep with wrap back to 0x00.
        for (int i = 0; i <= 64; i++) begin
            step(6'(i % 64));
            check($sformatf("sweep_%02h", i % 64), outs(), model(i % 64));
        end

        // Opcode change between edges must not reach the outputs early.
        step(6'h20);
        check("mid_load", outs(), 8'b0010_0000);
        #2 bus.opcode = 6'h24;
        #2 check("mid_hold", outs(), 8'b0010_0000);
        @(posedge clk);
        #1 check("mid_store", outs(), 8'b0001_0000);

        // Short reset pulse drops outputs and discards the pending decode.
        step(6'h2C);
        check("pulse_pre", outs(), 8'b0000_0001);
        bus.opcode = 6'h2C;
        #1 rst = 1'b1;
        #1 check("pulse_during", outs(), 8'h00);
        #1 rst = 1'b0;
        #1 check("pulse_after", outs(), 8'h00);
        @(posedge clk);
        #1 check("pulse_first_edge", outs(), 8'b0000_0001);

        // Random opcodes against the model, plus class exclusivity.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = int'($urandom_range(0, 63));
            step(6'(op));
            o = outs();
            check($sformatf("rand_%02h", op), o, model(op));
            cls = int'(o[7]) + int'(o[6]) + int'(o[5]) + int'(o[4]) + int'(o[3]) + int'(o[0]);
            n_checks++;
            if (cls > 1 && !(o[1] && cls == 1)) begin
                n_fail++;
                $display("FAIL exclusive_%02h: got %b expected at most one class flag", op, o);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
